tinynpu_ostream_drain: RTL and testbench

TINYNPU_OSTREAM_DRAIN -- requirements
Module: tinynpu_ostream_drain

---
 rtl/tinynpu_ostream_drain_if.sv | 27 ++
 rtl/tinynpu_ostream_drain.sv | 82 ++++++++
 tb/tb_tinynpu_ostream_drain.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tinynpu_ostream_drain_if.sv
// Drain-side bus: lane-result capture request, serial output stream and overflow status.
// The master modport is the drain block; the slave modport is the controller/consumer side.
interface tinynpu_ostream_drain_if #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 16
);
    logic                        c2d_ostream_req;
    logic [SIZE-1:0][DATA_W-1:0] d2o_acc_data;
    logic                        ostream_val;
    logic                        ostream_rdy;
    logic [DATA_W-1:0]           ostream_data;
    logic                        ostream_last;
    logic                        drain_busy;
    logic                        drain_done;
    logic                        ovf_err;
    logic                        ovf_clr;

    modport master (
        input  c2d_ostream_req, d2o_acc_data, ostream_rdy, ovf_clr,
        output ostream_val, ostream_data, ostream_last, drain_busy, drain_done, ovf_err
    );

    modport slave (
        output c2d_ostream_req, d2o_acc_data, ostream_rdy, ovf_clr,
        input  ostream_val, ostream_data, ostream_last, drain_busy, drain_done, ovf_err
    );
endinterface

// File: rtl/tinynpu_ostream_drain.sv
// Captures SIZE parallel MAC lane results and drains them as a valid/ready word stream.
// Optional TINYNPU_OSTREAM_RELU_EN clamps negative lanes to zero at capture.
module tinynpu_ostream_drain #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tinynpu_ostream_drain_if.master bus
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SIZE-1:0][DATA_W-1:0] buf_q, buf_d, cap;
    logic                        ovf_q, ovf_d;
    logic                        val_q, last_q;
    logic [DATA_W-1:0]           data_q;
    logic                        xfer, fin, accept, drop;

    always_comb begin
        cap = '0;
        for (int i = 0; i < SIZE; i++) begin
`ifdef TINYNPU_OSTREAM_RELU_EN
            cap[i] = bus.d2o_acc_data[i][DATA_W-1] ? '0 : bus.d2o_acc_data[i];
`else
            cap[i] = bus.d2o_acc_data[i];
`endif
        end
    end

    // A request landing on the last-word transfer chains straight into the next burst.
    assign xfer   = val_q & bus.ostream_rdy;
    assign fin    = xfer & last_q;
    assign accept = bus.c2d_ostream_req & ((state_q == IDLE) | fin);
    assign drop   = bus.c2d_ostream_req & (state_q == DRAIN) & ~fin;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (xfer) idx_d = fin ? '0 : idx_q + 1'b1;
        if (fin)  state_d = IDLE;
        if (accept) begin
            buf_d   = cap;
            idx_d   = '0;
            state_d = DRAIN;
        end
        ovf_d = drop | (ovf_q & ~bus.ovf_clr);
    end

    // Stream outputs are registered from next-state so nothing from d2o_acc_data reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            ovf_q   <= 1'b0;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            ovf_q   <= ovf_d;
            val_q   <= (state_d == DRAIN);
            last_q  <= (state_d == DRAIN) && (idx_d == LAST_IDX);
            data_q  <= (state_d == DRAIN) ? buf_d[idx_d] : '0;
        end
    end

    assign bus.ostream_val  = val_q;
    assign bus.ostream_data = data_q;
    assign bus.ostream_last = last_q;
    assign bus.drain_busy   = (state_q == DRAIN);
    assign bus.drain_done   = fin;
    assign bus.ovf_err      = ovf_q;
endmodule

// File: tb/tb_tinynpu_ostream_drain.sv
// Per-cycle vector table for tinynpu_ostream_drain plus a bounded latency sequence.
module tb_tinynpu_ostream_drain;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tinynpu_ostream_drain_if #(.SIZE(4), .DATA_W(16)) bus ();
    tinynpu_ostream_drain #(.SIZE(4), .DATA_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic            req;
        logic [3:0][15:0] d;
        logic            rdy, clr, rs;
        logic            ev;
        logic [15:0]     ed;
        logic            el, eb, edn, eo;
    } vec_t;

    localparam logic [3:0][15:0] LA = {16'd9, 16'd7, 16'hFFFD, 16'd5};
    localparam logic [3:0][15:0] LB = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [3:0][15:0] Z  = '0;
`ifdef TINYNPU_OSTREAM_RELU_EN
    localparam logic [15:0] M3 = 16'd0;
`else
    localparam logic [15:0] M3 = 16'hFFFD;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    function automatic vec_t V(logic req, logic [3:0][15:0] d, logic rdy, logic clr, logic rs,
                               logic ev, logic [15:0] ed, logic el, logic eb, logic edn, logic eo);
        vec_t v;
        v.req = req; v.d = d; v.rdy = rdy; v.clr = clr; v.rs = rs;
        v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.eo = eo;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.c2d_ostream_req = v.req;
        bus.d2o_acc_data    = v.d;
        bus.ostream_rdy     = v.rdy;
        bus.ovf_clr         = v.clr;
        rst                 = v.rs;
    endtask

    initial begin
        int lat;
        bit got;

        // reset cycle with a coincident request, then the request must not have been taken
        vq.push_back(V(1, LA, 1, 0, 1,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // plain burst, rdy held
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 7,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 9,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // backpressure on the second word
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  0, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  0, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 7,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 9,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // request mid-drain is dropped and latches overflow until cleared
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(1, LB, 1, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 7,    0, 1, 0, 1));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 9,    1, 1, 1, 1));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 1));
        vq.push_back(V(0, Z,  1, 1, 0,  0, 0,    0, 0, 0, 1));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // request on the last transfer chains into a new burst
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 7,    0, 1, 0, 0));
        vq.push_back(V(1, LB, 1, 0, 0,  1, 9,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 1,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 2,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 3,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 4,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // reset after two transfers, then a fresh burst from lane 0
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 1,  1, 7,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(1, LB, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 1,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 2,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 3,    0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 4,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));
        // drop with clear in the same cycle sets overflow; stalled last word holds done low
        vq.push_back(V(1, LA, 1, 0, 0,  0, 0,    0, 0, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 5,    0, 1, 0, 0));
        vq.push_back(V(1, LB, 1, 1, 0,  1, M3,   0, 1, 0, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 7,    0, 1, 0, 1));
        vq.push_back(V(0, Z,  0, 1, 0,  1, 9,    1, 1, 0, 1));
        vq.push_back(V(0, Z,  1, 0, 0,  1, 9,    1, 1, 1, 0));
        vq.push_back(V(0, Z,  1, 0, 0,  0, 0,    0, 0, 0, 0));

        drive(V(0, Z, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            drive(vq[i]);
            @(negedge clk);
            chk($sformatf("r%0d val", i),  {31'd0, bus.ostream_val},  {31'd0, vq[i].ev});
            chk($sformatf("r%0d data", i), {16'd0, bus.ostream_data}, {16'd0, vq[i].ed});
            chk($sformatf("r%0d last", i), {31'd0, bus.ostream_last}, {31'd0, vq[i].el});
            chk($sformatf("r%0d busy", i), {31'd0, bus.drain_busy},   {31'd0, vq[i].eb});
            chk($sformatf("r%0d done", i), {31'd0, bus.drain_done},   {31'd0, vq[i].edn});
            chk($sformatf("r%0d ovf", i),  {31'd0, bus.ovf_err},      {31'd0, vq[i].eo});
        end

        // request-to-done latency with a bounded wait
        @(posedge clk); #1;
        drive(V(1, LB, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        bus.c2d_ostream_req = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (bus.drain_done) begin
                got = 1'b1;
                lat = k;
                chk("done_word", {16'd0, bus.ostream_data}, 32'd4);
            end
            @(posedge clk); #1;
        end
        chk("done_latency", lat, 32'd4);
        @(negedge clk);
        chk("idle_after", {31'd0, bus.drain_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
